// File: rtl/arbiter_port_ctrl_if.sv
// Handshake bundle between the NoC port requester, its five input buffers, the 5-way arbiter and the output link.
// The master modport is the requester side. The slave modport is the surrounding environment.
interface arbiter_port_ctrl_if #(
   parameter int PKT_W   = 32,
   parameter int N_PORTS = 5,
   parameter int CNT_W   = 16
);
   logic [N_PORTS-1:0]       in_valid;
   logic [N_PORTS-1:0]       in_ready;
   logic [N_PORTS*PKT_W-1:0] in_data;
   logic                     arb_req_valid;
   logic                     arb_req_ready;
   logic [N_PORTS-1:0]       arb_req_data;
   logic                     arb_win_valid;
   logic                     arb_win_ready;
   logic [2:0]               arb_win_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [PKT_W-1:0]         out_data;
   logic                     err;
   logic [CNT_W-1:0]         pkt_cnt;

   modport master (
      input  in_valid, in_data, arb_req_ready, arb_win_valid, arb_win_data, out_ready,
      output in_ready, arb_req_valid, arb_req_data, arb_win_ready, out_valid, out_data,
             err, pkt_cnt
   );

   modport slave (
      output in_valid, in_data, arb_req_ready, arb_win_valid, arb_win_data, out_ready,
      input  in_ready, arb_req_valid, arb_req_data, arb_win_ready, out_valid, out_data,
             err, pkt_cnt
   );
endinterface

// File: rtl/arbiter_port_ctrl.sv
// Requester for a 5-way output arbiter: snapshot the valids, request, take the winner, forward one packet per round.
// Each round takes at least 4 cycles. out_ready low holds SEND, and no new request is issued until it rises.
module arbiter_port_ctrl #(
   parameter int PKT_W   = 32,
   parameter int N_PORTS = 5,
   parameter int CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   arbiter_port_ctrl_if.master  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WIN  = 2'd2,
      SEND = 2'd3
   } state_t;

   state_t             state_q,    state_d;
   logic [N_PORTS-1:0] snap_q,     snap_d;
   logic [PKT_W-1:0]   out_data_q, out_data_d;
   logic [N_PORTS-1:0] in_ready_q, in_ready_d;
   logic               err_q,      err_d;
   logic [CNT_W-1:0]   pkt_cnt_q,  pkt_cnt_d;

   logic               win_hit;
   logic [N_PORTS-1:0] win_onehot;
   logic [PKT_W-1:0]   win_pkt;

   // Loop-compare decode keeps indices 5..7 away from the snapshot/data vectors; they leave win_hit low.
   always_comb begin
      win_hit    = 1'b0;
      win_onehot = '0;
      win_pkt    = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (bus.arb_win_data == 3'(i)) begin
            win_hit       = snap_q[i];
            win_onehot[i] = 1'b1;
            win_pkt       = bus.in_data[i*PKT_W +: PKT_W];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      snap_d     = snap_q;
      out_data_d = out_data_q;
      in_ready_d = '0;
      err_d      = err_q;
      pkt_cnt_d  = pkt_cnt_q;
      case (state_q)
         IDLE: begin
            if (|bus.in_valid) begin
               snap_d  = bus.in_valid;
               state_d = REQ;
            end
         end
         REQ: begin
            if (bus.arb_req_ready) state_d = WIN;
         end
         WIN: begin
            if (bus.arb_win_valid) begin
               if (win_hit) begin
                  out_data_d = win_pkt;
                  in_ready_d = win_onehot;
                  state_d    = SEND;
               end else begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         SEND: begin
            if (bus.out_ready) begin
               pkt_cnt_d = pkt_cnt_q + 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         snap_q     <= '0;
         out_data_q <= '0;
         in_ready_q <= '0;
         err_q      <= 1'b0;
         pkt_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         snap_q     <= snap_d;
         out_data_q <= out_data_d;
         in_ready_q <= in_ready_d;
         err_q      <= err_d;
         pkt_cnt_q  <= pkt_cnt_d;
      end
   end

   assign bus.in_ready      = in_ready_q;
   assign bus.arb_req_valid = (state_q == REQ);
   assign bus.arb_req_data  = (state_q == REQ) ? snap_q : '0;
   assign bus.arb_win_ready = (state_q == WIN);
   assign bus.out_valid     = (state_q == SEND);
   assign bus.out_data      = out_data_q;
   assign bus.err           = err_q;
   assign bus.pkt_cnt       = pkt_cnt_q;

   a_ack_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(in_ready_q));
   a_send_hold  : assert property (@(posedge clk) disable iff (!rst_n)
                     (state_q == SEND && !bus.out_ready) |=> $stable(out_data_q));

endmodule

// File: tb/tb_arbiter_port_ctrl.sv
// Directed bench for arbiter_port_ctrl: latency, multi-round ordering, backpressure, illegal winners, reset, wrap.
module tb_arbiter_port_ctrl;
   localparam int PKT_W = 32;
   localparam int NP    = 5;
   localparam int CW    = 4;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;
   int   ack_cnt [NP];
   logic [PKT_W-1:0] hold_dat;

   arbiter_port_ctrl_if #(.PKT_W(PKT_W), .N_PORTS(NP), .CNT_W(CW)) bus ();

   arbiter_port_ctrl #(.PKT_W(PKT_W), .N_PORTS(NP), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one cycle; a source whose in_ready was high this cycle drops its valid after the edge.
   task automatic step();
      logic [NP-1:0] r;
      r = bus.in_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NP; i++) begin
         if (r[i]) begin
            bus.in_valid[i] = 1'b0;
            ack_cnt[i]++;
         end
      end
   endtask

   function automatic bit sig(input int sel);
      case (sel)
         0:       return bus.arb_req_valid;
         1:       return bus.arb_win_ready;
         2:       return bus.out_valid;
         default: return !bus.out_valid;
      endcase
   endfunction

   task automatic wait_for(input int sel, input string tag);
      int n;
      bit hit;
      n   = 0;
      hit = sig(sel);
      while (!hit && n < 20) begin
         step();
         n++;
         hit = sig(sel);
      end
      chk({tag, "_timeout"}, 64'(hit), 64'd1);
   endtask

   task automatic do_round(input logic [2:0] win, input logic [NP-1:0] exp_req,
                           input logic [PKT_W-1:0] exp_dat, input string tag);
      bus.arb_win_data = win;
      wait_for(0, {tag, "_req"});
      chk({tag, "_req_vec"}, 64'(bus.arb_req_data), 64'(exp_req));
      wait_for(2, {tag, "_out"});
      chk({tag, "_out_data"}, 64'(bus.out_data), 64'(exp_dat));
      wait_for(3, {tag, "_done"});
   endtask

   task automatic set_pkt(input int p, input logic [PKT_W-1:0] d);
      bus.in_data[p*PKT_W +: PKT_W] = d;
   endtask

   task automatic clr_acks();
      for (int i = 0; i < NP; i++) ack_cnt[i] = 0;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      clr_acks();
      rst_n             = 1'b0;
      bus.in_valid      = '0;
      bus.in_data       = '0;
      bus.arb_req_ready = 1'b1;
      bus.arb_win_valid = 1'b1;
      bus.arb_win_data  = 3'd0;
      bus.out_ready     = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready",  64'(bus.in_ready),      64'd0);
      chk("rst_req_valid", 64'(bus.arb_req_valid), 64'd0);
      chk("rst_req_data",  64'(bus.arb_req_data),  64'd0);
      chk("rst_win_ready", 64'(bus.arb_win_ready), 64'd0);
      chk("rst_out_valid", 64'(bus.out_valid),     64'd0);
      chk("rst_out_data",  64'(bus.out_data),      64'd0);
      chk("rst_err",       64'(bus.err),           64'd0);
      chk("rst_pkt_cnt",   64'(bus.pkt_cnt),       64'd0);
      rst_n = 1'b1;
      step();

      // T1: cycle-exact single packet from port 2
      set_pkt(2, 32'hA5A5_0002);
      bus.arb_win_data = 3'd2;
      bus.in_valid     = 5'b00100;
      step();
      chk("t1_e1_req_valid", 64'(bus.arb_req_valid), 64'd1);
      chk("t1_e1_req_data",  64'(bus.arb_req_data),  64'h04);
      chk("t1_e1_win_ready", 64'(bus.arb_win_ready), 64'd0);
      step();
      chk("t1_e2_win_ready", 64'(bus.arb_win_ready), 64'd1);
      chk("t1_e2_req_valid", 64'(bus.arb_req_valid), 64'd0);
      step();
      chk("t1_e3_out_valid", 64'(bus.out_valid),     64'd1);
      chk("t1_e3_out_data",  64'(bus.out_data),      64'hA5A5_0002);
      chk("t1_e3_in_ready",  64'(bus.in_ready),      64'h04);
      step();
      chk("t1_e4_out_valid", 64'(bus.out_valid),     64'd0);
      chk("t1_e4_in_ready",  64'(bus.in_ready),      64'd0);
      chk("t1_e4_pkt_cnt",   64'(bus.pkt_cnt),       64'd1);
      step();
      chk("t1_idle_req",     64'(bus.arb_req_valid), 64'd0);
      chk("t1_ack2",         64'(ack_cnt[2]),        64'd1);

      // T2: three requesters served in the order 4, 1, 0
      clr_acks();
      set_pkt(0, 32'h0000_1000);
      set_pkt(1, 32'h0000_1001);
      set_pkt(4, 32'h0000_1004);
      bus.in_valid = 5'b10011;
      do_round(3'd4, 5'b10011, 32'h0000_1004, "t2_r1");
      do_round(3'd1, 5'b00011, 32'h0000_1001, "t2_r2");
      do_round(3'd0, 5'b00001, 32'h0000_1000, "t2_r3");
      chk("t2_ack0",    64'(ack_cnt[0]),   64'd1);
      chk("t2_ack1",    64'(ack_cnt[1]),   64'd1);
      chk("t2_ack4",    64'(ack_cnt[4]),   64'd1);
      chk("t2_pkt_cnt", 64'(bus.pkt_cnt),  64'd4);

      // T3: downstream stalls for 10 cycles in SEND
      clr_acks();
      set_pkt(3, 32'hBEEF_0003);
      bus.out_ready    = 1'b0;
      bus.arb_win_data = 3'd3;
      bus.in_valid     = 5'b01000;
      wait_for(2, "t3_out");
      hold_dat = 32'hBEEF_0003;
      chk("t3_first_data", 64'(bus.out_data), 64'(hold_dat));
      for (int k = 0; k < 10; k++) begin
         step();
         chk("t3_hold_valid", 64'(bus.out_valid),     64'd1);
         chk("t3_hold_data",  64'(bus.out_data),      64'(hold_dat));
         chk("t3_hold_req",   64'(bus.arb_req_valid), 64'd0);
         chk("t3_hold_ack",   64'(bus.in_ready),      64'd0);
      end
      bus.out_ready = 1'b1;
      step();
      chk("t3_release_valid", 64'(bus.out_valid), 64'd0);
      chk("t3_pkt_cnt",       64'(bus.pkt_cnt),   64'd5);
      chk("t3_ack3",          64'(ack_cnt[3]),    64'd1);

      // T4: winner 3 (not requesting), then 7 (out of range), then a legal round
      clr_acks();
      set_pkt(0, 32'hC0DE_0000);
      bus.arb_win_data = 3'd3;
      bus.in_valid     = 5'b00001;
      wait_for(0, "t4_req");
      chk("t4_req_vec", 64'(bus.arb_req_data), 64'h01);
      wait_for(1, "t4_win_a");
      step();
      chk("t4a_err",       64'(bus.err),           64'd1);
      chk("t4a_out_valid", 64'(bus.out_valid),     64'd0);
      chk("t4a_in_ready",  64'(bus.in_ready),      64'd0);
      chk("t4a_idle",      64'(bus.arb_win_ready | bus.arb_req_valid), 64'd0);
      bus.arb_win_data = 3'd7;
      wait_for(1, "t4_win_b");
      step();
      chk("t4b_err",       64'(bus.err),           64'd1);
      chk("t4b_out_valid", 64'(bus.out_valid),     64'd0);
      chk("t4b_ack0",      64'(ack_cnt[0]),        64'd0);
      do_round(3'd0, 5'b00001, 32'hC0DE_0000, "t4_ok");
      chk("t4_ack0",    64'(ack_cnt[0]),  64'd1);
      chk("t4_err_sticky", 64'(bus.err),  64'd1);
      chk("t4_pkt_cnt", 64'(bus.pkt_cnt), 64'd6);

      // T5: reset lands in the first SEND cycle, before the source consumes the ack
      clr_acks();
      set_pkt(1, 32'h5EED_0001);
      bus.out_ready    = 1'b0;
      bus.arb_win_data = 3'd1;
      bus.in_valid     = 5'b00010;
      wait_for(2, "t5_out");
      chk("t5_ack_pulse", 64'(bus.in_ready), 64'h02);
      #1 rst_n = 1'b0;
      #1;
      chk("t5_rst_in_ready",  64'(bus.in_ready),      64'd0);
      chk("t5_rst_out_valid", 64'(bus.out_valid),     64'd0);
      chk("t5_rst_out_data",  64'(bus.out_data),      64'd0);
      chk("t5_rst_req",       64'(bus.arb_req_valid), 64'd0);
      chk("t5_rst_win",       64'(bus.arb_win_ready), 64'd0);
      chk("t5_rst_err",       64'(bus.err),           64'd0);
      chk("t5_rst_pkt_cnt",   64'(bus.pkt_cnt),       64'd0);
      step();
      step();
      chk("t5_no_ack", 64'(ack_cnt[1]), 64'd0);
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      do_round(3'd1, 5'b00010, 32'h5EED_0001, "t5_again");
      chk("t5_ack1",    64'(ack_cnt[1]),  64'd1);
      chk("t5_pkt_cnt", 64'(bus.pkt_cnt), 64'd1);

      // T6: counter wraps with CNT_W=4
      for (int r = 0; r < 14; r++) begin
         set_pkt(4, 32'h7000_0000 + 32'(r));
         bus.in_valid = 5'b10000;
         do_round(3'd4, 5'b10000, 32'h7000_0000 + 32'(r), "t6_round");
      end
      chk("t6_pkt_cnt_15", 64'(bus.pkt_cnt), 64'd15);
      set_pkt(4, 32'h7000_00FF);
      bus.in_valid = 5'b10000;
      do_round(3'd4, 5'b10000, 32'h7000_00FF, "t6_last");
      chk("t6_pkt_cnt_wrap", 64'(bus.pkt_cnt), 64'd0);
      chk("t6_err_clear",    64'(bus.err),     64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
